// File: rtl/i2c_target_regport_if.sv
// Pad and register-file signals of the I2C target register port.
// The slave modport is the target's view; master is the SoC/bench side.
interface i2c_target_regport_if #(
  parameter int unsigned PTR_W = 4
);
  logic             scl_i;
  logic             sda_i;
  logic             sda_oe_o;
  logic             wr_stb_o;
  logic [PTR_W-1:0] wr_addr_o;
  logic [7:0]       wr_data_o;
  logic [PTR_W-1:0] rd_addr_o;
  logic [7:0]       rd_data_i;
  logic             addressed_o;

  modport slave (
    input  scl_i, sda_i, rd_data_i,
    output sda_oe_o, wr_stb_o, wr_addr_o, wr_data_o, rd_addr_o, addressed_o
  );

  modport master (
    output scl_i, sda_i, rd_data_i,
    input  sda_oe_o, wr_stb_o, wr_addr_o, wr_data_o, rd_addr_o, addressed_o
  );
endinterface

// File: rtl/i2c_target_regport.sv
// I2C target that maps bus writes to register-file strobes and serves reads
// with pointer auto-increment. Open-drain SDA, no clock stretching.
module i2c_target_regport #(
  parameter logic [6:0]  TARGET_ADDR = 7'h42,
  parameter int unsigned PTR_W       = 4
) (
  input logic                  wb_clk,
  input logic                  wb_rst_n,
  i2c_target_regport_if.slave  bus
);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StAddr     = 4'd1;
  localparam logic [3:0] StAddrAck  = 4'd2;
  localparam logic [3:0] StPtr      = 4'd3;
  localparam logic [3:0] StPtrAck   = 4'd4;
  localparam logic [3:0] StWdata    = 4'd5;
  localparam logic [3:0] StWdataAck = 4'd6;
  localparam logic [3:0] StRdata    = 4'd7;
  localparam logic [3:0] StRack     = 4'd8;
  localparam logic [3:0] StWait     = 4'd9;

  localparam logic [PTR_W-1:0] PtrOne = {{(PTR_W-1){1'b0}}, 1'b1};

  // [0],[1] synchronizer stages, [2] history for edge detection
  logic [2:0] scl_sync_q, sda_sync_q;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[1:0], bus.sda_i};
    end
  end

  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;
  assign scl       = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  = scl & ~scl_sync_q[2];
  assign scl_fall  = ~scl & scl_sync_q[2];
  assign start_det = scl & scl_sync_q[2] & sda_sync_q[2] & ~sda;
  assign stop_det  = scl & scl_sync_q[2] & ~sda_sync_q[2] & sda;

  logic [3:0]       state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  // In ACK states: set once the ACK low has been driven. In StRack: set once
  // the master's ACK has been sampled.
  logic             ack_drv_q, ack_drv_d;
  logic             sda_oe_q, sda_oe_d;
  logic             addressed_q, addressed_d;
  logic             wr_stb_q, wr_stb_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;

  logic [7:0] rx_byte;
  logic       last_bit;
  assign rx_byte  = {shreg_q[6:0], sda};
  assign last_bit = (bitcnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_drv_d   = ack_drv_q;
    sda_oe_d    = sda_oe_q;
    addressed_d = addressed_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (start_det) begin
      state_d     = StAddr;
      bitcnt_d    = 3'd0;
      ack_drv_d   = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else if (stop_det) begin
      state_d     = StIdle;
      ack_drv_d   = 1'b0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shreg_d  = rx_byte;
            bitcnt_d = bitcnt_q + 3'd1;
            if (last_bit) begin
              ack_drv_d = 1'b0;
              if (state_q == StAddr) begin
                rw_d    = rx_byte[0];
                state_d = (rx_byte[7:1] == TARGET_ADDR) ? StAddrAck : StWait;
              end else if (state_q == StPtr) begin
                ptr_d   = rx_byte[PTR_W-1:0];
                state_d = StPtrAck;
              end else begin
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = rx_byte;
                ptr_d     = ptr_q + PtrOne;
                state_d   = StWdataAck;
              end
            end
          end
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_oe_d  = 1'b1;
              ack_drv_d = 1'b1;
              if (state_q == StAddrAck) addressed_d = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              bitcnt_d  = 3'd0;
              if (state_q == StAddrAck && rw_q) begin
                shreg_d  = bus.rd_data_i;
                sda_oe_d = ~bus.rd_data_i[7];
                state_d  = StRdata;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = (state_q == StAddrAck) ? StPtr : StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_fall) begin
            if (last_bit) begin
              sda_oe_d  = 1'b0;
              ack_drv_d = 1'b0;
              state_d   = StRack;
            end else begin
              sda_oe_d = ~shreg_q[6];
              shreg_d  = {shreg_q[6:0], 1'b0};
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
        end
        StRack: begin
          if (scl_rise && !ack_drv_q) begin
            ptr_d = ptr_q + PtrOne;
            if (sda) state_d = StWait;
            else     ack_drv_d = 1'b1;
          end else if (scl_fall && ack_drv_q) begin
            // rd_addr_o moved at the rising edge, so rd_data_i is settled here
            ack_drv_d = 1'b0;
            shreg_d   = bus.rd_data_i;
            sda_oe_d  = ~bus.rd_data_i[7];
            bitcnt_d  = 3'd0;
            state_d   = StRdata;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= StIdle;
      bitcnt_q    <= 3'd0;
      shreg_q     <= 8'h00;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ack_drv_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      addressed_q <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_drv_q   <= ack_drv_d;
      sda_oe_q    <= sda_oe_d;
      addressed_q <= addressed_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.sda_oe_o    = sda_oe_q;
  assign bus.wr_stb_o    = wr_stb_q;
  assign bus.wr_addr_o   = wr_addr_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.rd_addr_o   = ptr_q;
  assign bus.addressed_o = addressed_q;

endmodule

// File: tb/tb_i2c_target_regport.sv
// Bench for i2c_target_regport: bit-level I2C master, register-file model,
// transaction-level reference model and a queue-based scoreboard.
`timescale 1ns/1ps
module tb_i2c_target_regport;

  localparam int unsigned PTR_W = 4;
  localparam logic [6:0]  TADDR = 7'h42;
  localparam int          Q     = 80;  // quarter SCL period in ns

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_target_regport_if #(.PTR_W(PTR_W)) bus ();

  logic scl = 1'b1;
  logic m_sda = 1'b1;
  logic [7:0] env_mem [16];

  assign bus.scl_i     = scl;
  assign bus.sda_i     = m_sda & ~bus.sda_oe_o;
  assign bus.rd_data_i = env_mem[bus.rd_addr_o];

  i2c_target_regport #(.TARGET_ADDR(TADDR), .PTR_W(PTR_W)) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .bus      (bus.slave)
  );

  // Reference model: register contents and pointer as the bus rules define them
  logic [7:0]  ref_mem [16];
  logic [3:0]  ref_ptr = 4'd0;
  logic [11:0] exp_wr_q[$];
  logic        exp_ack_q[$], obs_ack_q[$];
  logic [7:0]  exp_rd_q[$], obs_rd_q[$];
  logic [7:0]  txq[$];

  int   n_vec = 0;
  int   n_err = 0;
  logic watch_oe = 1'b0;
  logic oe_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External register file fed by the DUT strobes
  initial begin
    for (int i = 0; i < 16; i++) env_mem[i] = 8'hC0 + 8'(i);
    forever begin
      @(negedge clk);
      if (bus.wr_stb_o) env_mem[bus.wr_addr_o] = bus.wr_data_o;
    end
  end

  // Scoreboard monitor
  initial begin
    logic [11:0] e;
    logic        a, ea;
    logic [7:0]  r, er;
    forever begin
      @(negedge clk);
      if (bus.wr_stb_o) begin
        if (exp_wr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL wr_strobe: got addr %0h data %0h, required no strobe",
                   bus.wr_addr_o, bus.wr_data_o);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_strobe", {20'h0, bus.wr_addr_o, bus.wr_data_o}, {20'h0, e});
        end
      end
      while (obs_ack_q.size() > 0) begin
        a = obs_ack_q.pop_front();
        if (exp_ack_q.size() == 0) check("ack_unexpected", 32'(a), 32'hFFFF);
        else begin
          ea = exp_ack_q.pop_front();
          check("ack_bit", 32'(a), 32'(ea));
        end
      end
      while (obs_rd_q.size() > 0) begin
        r = obs_rd_q.pop_front();
        if (exp_rd_q.size() == 0) check("rd_unexpected", 32'(r), 32'hFFFF);
        else begin
          er = exp_rd_q.pop_front();
          check("rd_byte", 32'(r), 32'(er));
        end
      end
      if (watch_oe && bus.sda_oe_o) oe_seen = 1'b1;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic i2c_start();
    m_sda = 1'b1; #(Q);
    scl = 1'b1;   #(Q);
    m_sda = 1'b0; #(Q);
    scl = 1'b0;   #(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #(Q);
    scl = 1'b1;   #(Q);
    m_sda = 1'b1; #(2 * Q);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    if (glitch) begin
      m_sda = ~b; #(Q / 4);
      m_sda = b;  #(Q / 4);
      m_sda = ~b; #(Q / 4);
      m_sda = b;  #(Q / 4);
    end else begin
      m_sda = b; #(Q);
    end
    scl = 1'b1; #(2 * Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; #(Q);
    scl = 1'b1;   #(Q);
    b = bus.sda_i; #(Q);
    scl = 1'b0;   #(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, input logic glitch);
    logic ack;
    for (int i = 0; i < 8; i++) write_bit(v[7-i], glitch && (i == 3));
    read_bit(ack);
    obs_ack_q.push_back(ack);
  endtask

  task automatic read_byte(input logic nack);
    logic [7:0] v;
    logic       b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v = {v[6:0], b};
    end
    write_bit(nack, 1'b0);
    obs_rd_q.push_back(v);
  endtask

  task automatic end_checks(input logic exp_addressed);
    check("addressed_o", 32'(bus.addressed_o), 32'(exp_addressed));
    i2c_stop();
    repeat (8) @(negedge clk);
    check("addressed_after_stop", 32'(bus.addressed_o), 32'h0);
    check("rd_addr_o", 32'(bus.rd_addr_o), 32'(ref_ptr));
  endtask

  // txq holds pointer byte then data bytes
  task automatic txn_write(input logic [6:0] a7, input int glitch_byte);
    logic match;
    match = (a7 == TADDR);
    i2c_start();
    exp_ack_q.push_back(~match);
    write_byte({a7, 1'b0}, 1'b0);
    for (int i = 0; i < txq.size(); i++) begin
      if (match) begin
        if (i == 0) ref_ptr = txq[0][3:0];
        else begin
          exp_wr_q.push_back({ref_ptr, txq[i]});
          ref_mem[ref_ptr] = txq[i];
          ref_ptr = ref_ptr + 4'd1;
        end
      end
      exp_ack_q.push_back(~match);
      write_byte(txq[i], i == glitch_byte);
    end
    end_checks(match);
  endtask

  task automatic txn_read(input logic set_ptr, input logic [7:0] ptr_byte, input int n);
    i2c_start();
    if (set_ptr) begin
      exp_ack_q.push_back(1'b0);
      write_byte({TADDR, 1'b0}, 1'b0);
      ref_ptr = ptr_byte[3:0];
      exp_ack_q.push_back(1'b0);
      write_byte(ptr_byte, 1'b0);
      i2c_start();
    end
    exp_ack_q.push_back(1'b0);
    write_byte({TADDR, 1'b1}, 1'b0);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(ref_mem[ref_ptr]);
      ref_ptr = ref_ptr + 4'd1;
      read_byte(i == n - 1);
    end
    end_checks(1'b1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'hC0 + 8'(i);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sda_oe", 32'(bus.sda_oe_o), 32'h0);
    check("rst_rd_addr", 32'(bus.rd_addr_o), 32'h0);
    check("rst_addressed", 32'(bus.addressed_o), 32'h0);
    check("rst_wr_stb", 32'(bus.wr_stb_o), 32'h0);
    check("rst_wr_addr_data", {20'h0, bus.wr_addr_o, bus.wr_data_o}, 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Register write: strobes (3,A5) and (4,5A)
    txq = '{8'h03, 8'hA5, 8'h5A};
    txn_write(TADDR, -1);

    // Read with wrap: 0xCF then 0xC0, pointer ends at 1
    txn_read(1'b1, 8'h0F, 2);
    check("wrap_rd_addr", 32'(bus.rd_addr_o), 32'h1);

    // Address mismatch (0x90): never pulls SDA, pointer unchanged
    oe_seen = 1'b0;
    watch_oe = 1'b1;
    txq = '{8'h03, 8'h11};
    txn_write(7'h48, -1);
    watch_oe = 1'b0;
    check("mismatch_oe_seen", 32'(oe_seen), 32'h0);

    // Aborted write: partial byte discarded, then a write of 0x77 to reg 2
    i2c_start();
    exp_ack_q.push_back(1'b0);
    write_byte({TADDR, 1'b0}, 1'b0);
    exp_ack_q.push_back(1'b0);
    write_byte(8'h05, 1'b0);
    ref_ptr = 4'd5;
    for (int i = 0; i < 4; i++) write_bit(i[0], 1'b0);
    end_checks(1'b1);
    txq = '{8'h02, 8'h77};
    txn_write(TADDR, -1);

    // Glitches on SDA while SCL is low inside a data byte
    txq = '{8'h06, 8'h3C};
    txn_write(TADDR, 1);

    // Reset mid-read: reg 9 holds 0x00 so the MSB drives SDA low
    txq = '{8'h09, 8'h00};
    txn_write(TADDR, -1);
    i2c_start();
    exp_ack_q.push_back(1'b0);
    write_byte({TADDR, 1'b0}, 1'b0);
    exp_ack_q.push_back(1'b0);
    write_byte(8'h09, 1'b0);
    i2c_start();
    exp_ack_q.push_back(1'b0);
    write_byte({TADDR, 1'b1}, 1'b0);
    check("oe_before_reset", 32'(bus.sda_oe_o), 32'h1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_sda_oe", 32'(bus.sda_oe_o), 32'h0);
    check("async_rst_rd_addr", 32'(bus.rd_addr_o), 32'h0);
    check("async_rst_addressed", 32'(bus.addressed_o), 32'h0);
    ref_ptr = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    m_sda = 1'b1;
    #(Q);
    scl = 1'b1;
    #(2 * Q);
    txn_read(1'b0, 8'h00, 2);
    txq = '{8'h0E, 8'h12, 8'h34, 8'h56};
    txn_write(TADDR, -1);

    // Randomized transactions
    for (int k = 0; k < 16; k++) begin
      int         kind;
      int         nb;
      logic [6:0] a;
      kind = int'($urandom_range(0, 5));
      nb   = int'($urandom_range(1, 3));
      txq.delete();
      txq.push_back(8'($urandom_range(0, 255)));
      for (int j = 0; j < nb; j++) txq.push_back(8'($urandom_range(0, 255)));
      if (kind <= 2) txn_write(TADDR, -1);
      else if (kind == 3) begin
        a = 7'($urandom_range(0, 127));
        if (a == TADDR) a = a + 7'd1;
        txn_write(a, -1);
      end else if (kind == 4) txn_read(1'b1, txq[0], nb);
      else txn_read(1'b0, 8'h00, nb);
    end

    repeat (20) @(negedge clk);
    check("exp_wr_left", 32'(exp_wr_q.size()), 32'h0);
    check("exp_ack_left", 32'(exp_ack_q.size()), 32'h0);
    check("exp_rd_left", 32'(exp_rd_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
